// File: rtl/cfs_md_pkg.sv
// Shared MD-protocol definitions: responder state type, byte-lane helpers and
// the transfer legality rule used by the responder and the aligner checkers.
package cfs_md_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } md_rsp_state_t;

  localparam int unsigned MD_DATA_WIDTH = 32;
  localparam int unsigned MD_BYTES      = MD_DATA_WIDTH / 8;

  function automatic int unsigned md_off_width(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int unsigned md_size_width(input int unsigned data_width);
    return md_off_width(data_width) + 1;
  endfunction

  // A transfer must be non-empty, fit in the bus and be naturally aligned to its size.
  function automatic logic md_is_legal(input int unsigned offset, input int unsigned size,
                                       input int unsigned bytes = MD_BYTES);
    if (size == 0) return 1'b0;
    if (offset + size > bytes) return 1'b0;
    return ((bytes + offset) % size) == 0;
  endfunction

  function automatic logic [31:0] md_sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/cfs_md_byte_extract.sv
// Right-justifies the valid byte window of an MD payload and zeroes the bytes above it.
module cfs_md_byte_extract
  import cfs_md_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned OffWidth  = md_off_width(DataWidth),
  parameter int unsigned SizeWidth = OffWidth + 1
) (
  input  logic [DataWidth-1:0] data_i,
  input  logic [OffWidth-1:0]  offset_i,
  input  logic [SizeWidth-1:0] size_i,
  output logic [DataWidth-1:0] data_o
);

  localparam int unsigned Bytes = DataWidth / 8;

  logic [DataWidth-1:0] shifted;

  always_comb begin
    shifted = data_i >> {offset_i, 3'b000};
    data_o  = '0;
    for (int unsigned i = 0; i < Bytes; i++) begin
      if (i < 32'(size_i)) data_o[8*i +: 8] = shifted[8*i +: 8];
    end
  end

endmodule

// File: rtl/cfs_md_responder.sv
// MD-protocol slave: programmable wait states, legality check, byte extraction,
// saturating statistics and a sticky flag for masters that break the hold rule.
module cfs_md_responder
  import cfs_md_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAIT_WIDTH = 4,
  parameter int unsigned OW         = md_off_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  md_valid,
  input  logic [DATA_WIDTH-1:0] md_data,
  input  logic [OW-1:0]         md_offset,
  input  logic [OW:0]           md_size,
  output logic                  md_ready,
  output logic                  md_err,
  input  logic [WAIT_WIDTH-1:0] cfg_wait,
  input  logic                  clr,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OW:0]           out_size,
  output logic [31:0]           cnt_xfers,
  output logic [31:0]           cnt_bytes,
  output logic [31:0]           cnt_err,
  output logic                  proto_viol
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;

  md_rsp_state_t         state_q, state_d;
  logic [WAIT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [OW-1:0]         offset_q, offset_d;
  logic [OW:0]           size_q, size_d;
  logic                  legal_q, legal_d;
  logic                  md_ready_q, md_ready_d;
  logic                  md_err_q, md_err_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [OW:0]           out_size_q, out_size_d;
  logic [31:0]           cnt_xfers_q, cnt_xfers_d;
  logic [31:0]           cnt_bytes_q, cnt_bytes_d;
  logic [31:0]           cnt_err_q, cnt_err_d;
  logic                  proto_viol_q, proto_viol_d;
  logic [DATA_WIDTH-1:0] extracted;
  logic                  legal_now;

  cfs_md_byte_extract #(
    .DataWidth (DATA_WIDTH),
    .OffWidth  (OW),
    .SizeWidth (OW + 1)
  ) u_extract (
    .data_i   (data_q),
    .offset_i (offset_q),
    .size_i   (size_q),
    .data_o   (extracted)
  );

  assign legal_now = md_is_legal(32'(md_offset), 32'(md_size), Bytes);

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    data_d       = data_q;
    offset_d     = offset_q;
    size_d       = size_q;
    legal_d      = legal_q;
    md_ready_d   = 1'b0;
    md_err_d     = 1'b0;
    out_valid_d  = 1'b0;
    out_data_d   = out_data_q;
    out_size_d   = out_size_q;
    cnt_xfers_d  = cnt_xfers_q;
    cnt_bytes_d  = cnt_bytes_q;
    cnt_err_d    = cnt_err_q;
    proto_viol_d = proto_viol_q;

    unique case (state_q)
      StIdle: begin
        if (md_valid) begin
          data_d   = md_data;
          offset_d = md_offset;
          size_d   = md_size;
          wcnt_d   = cfg_wait;
          legal_d  = legal_now;
          if (cfg_wait != '0) begin
            state_d = StWait;
          end else begin
            state_d    = StResp;
            md_ready_d = 1'b1;
            md_err_d   = ~legal_now;
          end
        end
      end
      StWait: begin
        if (!md_valid || md_data != data_q || md_offset != offset_q || md_size != size_q) begin
          state_d      = StIdle;
          proto_viol_d = 1'b1;
        end else if (wcnt_q <= WAIT_WIDTH'(1)) begin
          state_d    = StResp;
          md_ready_d = 1'b1;
          md_err_d   = ~legal_q;
        end else begin
          wcnt_d = wcnt_q - WAIT_WIDTH'(1);
        end
      end
      StResp: begin
        // Statistics and the output pulse commit on leaving RESP, so a reset
        // during RESP leaves no partial update behind.
        state_d     = StIdle;
        cnt_xfers_d = md_sat_add(cnt_xfers_q, 32'd1);
        if (legal_q) begin
          out_valid_d = 1'b1;
          out_data_d  = extracted;
          out_size_d  = size_q;
          cnt_bytes_d = md_sat_add(cnt_bytes_q, 32'(size_q));
        end else begin
          cnt_err_d = md_sat_add(cnt_err_q, 32'd1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      cnt_xfers_d  = '0;
      cnt_bytes_d  = '0;
      cnt_err_d    = '0;
      proto_viol_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wcnt_q       <= '0;
      data_q       <= '0;
      offset_q     <= '0;
      size_q       <= '0;
      legal_q      <= 1'b0;
      md_ready_q   <= 1'b0;
      md_err_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_size_q   <= '0;
      cnt_xfers_q  <= '0;
      cnt_bytes_q  <= '0;
      cnt_err_q    <= '0;
      proto_viol_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      data_q       <= data_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      legal_q      <= legal_d;
      md_ready_q   <= md_ready_d;
      md_err_q     <= md_err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_size_q   <= out_size_d;
      cnt_xfers_q  <= cnt_xfers_d;
      cnt_bytes_q  <= cnt_bytes_d;
      cnt_err_q    <= cnt_err_d;
      proto_viol_q <= proto_viol_d;
    end
  end

  assign md_ready   = md_ready_q;
  assign md_err     = md_err_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_size   = out_size_q;
  assign cnt_xfers  = cnt_xfers_q;
  assign cnt_bytes  = cnt_bytes_q;
  assign cnt_err    = cnt_err_q;
  assign proto_viol = proto_viol_q;

endmodule

// File: tb/tb_cfs_md_responder.sv
// Self-checking bench for cfs_md_responder (DATA_WIDTH=32): directed table, corner
// sequences and randomized transfers against a transaction-level model.
module tb_cfs_md_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        md_valid;
  logic [31:0] md_data;
  logic [1:0]  md_offset;
  logic [2:0]  md_size;
  logic        md_ready;
  logic        md_err;
  logic [3:0]  cfg_wait;
  logic        clr;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_size;
  logic [31:0] cnt_xfers;
  logic [31:0] cnt_bytes;
  logic [31:0] cnt_err;
  logic        proto_viol;

  int total = 0;
  int bad   = 0;

  longint unsigned m_x, m_b, m_e;

  cfs_md_responder #(
    .DATA_WIDTH (32),
    .WAIT_WIDTH (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .md_valid   (md_valid),
    .md_data    (md_data),
    .md_offset  (md_offset),
    .md_size    (md_size),
    .md_ready   (md_ready),
    .md_err     (md_err),
    .cfg_wait   (cfg_wait),
    .clr        (clr),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_size   (out_size),
    .cnt_xfers  (cnt_xfers),
    .cnt_bytes  (cnt_bytes),
    .cnt_err    (cnt_err),
    .proto_viol (proto_viol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          off;
    int          size;
    int          w;
    bit          err;
    logic [31:0] out;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_legal(input int off, input int size);
    if (size == 0 || off + size > 4) return 1'b0;
    return ((4 + off) % size) == 0;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [31:0] d, input int off, input int size);
    logic [31:0] r = 0;
    for (int b = 0; b < size; b++) r |= ((d >> (8 * (off + b))) & 32'hff) << (8 * b);
    return r;
  endfunction

  function automatic longint unsigned sat(input longint unsigned v);
    return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_cnt_xfers"}, cnt_xfers, m_x);
    check({tag, "_cnt_bytes"}, cnt_bytes, m_b);
    check({tag, "_cnt_err"}, cnt_err, m_e);
  endtask

  task automatic run_xfer(input logic [31:0] d, input int off, input int sz, input int w,
                          input bit exp_err, input logic [31:0] exp_out);
    logic [31:0] offv = off;
    logic [31:0] szv  = sz;
    logic [31:0] wv   = w;
    md_data   = d;
    md_offset = offv[1:0];
    md_size   = szv[2:0];
    cfg_wait  = wv[3:0];
    md_valid  = 1'b1;
    tick();
    cfg_wait = 4'($urandom_range(0, 15));
    for (int c = 0; c <= w; c++) begin
      if (c > 0) tick();
      check("ready_timing", md_ready, c == w);
    end
    check("err", md_err, exp_err);
    md_valid = 1'b0;
    tick();
    check("ready_pulse", md_ready, 0);
    check("out_valid", out_valid, !exp_err);
    if (!exp_err) begin
      check("out_data", out_data, exp_out);
      check("out_size", out_size, sz);
    end
    m_x = sat(m_x + 1);
    if (exp_err) m_e = sat(m_e + 1);
    else m_b = sat(m_b + sz);
    check_counters("xfer");
  endtask

  task automatic run_viol(input logic [31:0] d, input bit change_data);
    md_data   = d;
    md_offset = 2'd0;
    md_size   = 3'd4;
    cfg_wait  = 4'd5;
    md_valid  = 1'b1;
    tick();
    tick();
    if (change_data) md_data = ~d;
    else md_valid = 1'b0;
    tick();
    md_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("viol_no_ready", md_ready, 0);
      tick();
    end
    check("viol_flag", proto_viol, 1);
    check_counters("viol");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("viol_clr", proto_viol, 0);
    m_x = 0; m_b = 0; m_e = 0;
    check_counters("viol_clr");
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{32'hDDCCBBAA, 1, 2, 0, 1'b1, 32'h0});       // (4+1)%2 != 0
    vecs.push_back('{32'hDDCCBBAA, 2, 2, 0, 1'b0, 32'h0000DDCC});
    vecs.push_back('{32'h11223344, 0, 4, 3, 1'b0, 32'h11223344});
    vecs.push_back('{32'hDDCCBBAA, 1, 1, 1, 1'b0, 32'h000000BB});
    vecs.push_back('{32'hDDCCBBAA, 3, 2, 0, 1'b1, 32'h0});
    vecs.push_back('{32'hDDCCBBAA, 0, 0, 2, 1'b1, 32'h0});
    vecs.push_back('{32'hDDCCBBAA, 3, 1, 0, 1'b0, 32'h000000DD});
    vecs.push_back('{32'hCAFEF00D, 0, 2, 1, 1'b0, 32'h0000F00D});
    vecs.push_back('{32'hCAFEF00D, 0, 3, 0, 1'b1, 32'h0});
    vecs.push_back('{32'h12345678, 0, 5, 2, 1'b1, 32'h0});

    reset_n = 1'b0; md_valid = 1'b0; md_data = '0; md_offset = '0; md_size = '0;
    cfg_wait = '0; clr = 1'b0;
    m_x = 0; m_b = 0; m_e = 0;
    tick();
    tick();
    check("rst_ready", md_ready, 0);
    check("rst_err", md_err, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_size", out_size, 0);
    check("rst_viol", proto_viol, 0);
    check_counters("rst");
    reset_n = 1'b1;
    tick();

    foreach (vecs[i])
      run_xfer(vecs[i].data, vecs[i].off, vecs[i].size, vecs[i].w, vecs[i].err, vecs[i].out);

    // Master holds md_valid: one transfer every cfg_wait+2 cycles.
    md_data = 32'hA5A5_5A5A; md_offset = 2'd0; md_size = 3'd4; cfg_wait = 4'd1;
    md_valid = 1'b1;
    tick();
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      check("b2b_ready", md_ready, (c % 3) == 1);
      if (c == 8) md_valid = 1'b0;
    end
    tick();
    m_x += 3; m_b += 12;
    check_counters("b2b");

    run_viol(32'h0BAD_F00D, 1'b0);
    run_viol(32'h600D_CAFE, 1'b1);

    // Saturation from a preloaded near-max state.
    force dut.cnt_xfers_q = 32'hFFFF_FFFE;
    force dut.cnt_bytes_q = 32'hFFFF_FFFD;
    #2;
    release dut.cnt_xfers_q;
    release dut.cnt_bytes_q;
    m_x = 64'hFFFF_FFFE; m_b = 64'hFFFF_FFFD;
    run_xfer(32'h01020304, 0, 4, 0, 1'b0, 32'h01020304);
    check("sat_xfers", cnt_xfers, 32'hFFFF_FFFF);
    run_xfer(32'h01020304, 2, 1, 1, 1'b0, 32'h00000002);
    check("sat_bytes", cnt_bytes, 32'hFFFF_FFFF);

    // clr in the completion cycle wins over the update.
    md_data = 32'h55667788; md_offset = 2'd0; md_size = 3'd2; cfg_wait = 4'd0;
    md_valid = 1'b1;
    tick();
    check("clr_col_ready", md_ready, 1);
    md_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_col_out_valid", out_valid, 1);
    check("clr_col_out_data", out_data, 32'h00007788);
    m_x = 0; m_b = 0; m_e = 0;
    check_counters("clr_col");

    // Reset while in RESP drops ready/err at once.
    run_xfer(32'h0, 3, 2, 0, 1'b1, 32'h0);
    md_data = 32'hDDCCBBAA; md_offset = 2'd3; md_size = 3'd2; cfg_wait = 4'd2;
    md_valid = 1'b1;
    tick(); tick(); tick();
    check("rresp_ready", md_ready, 1);
    check("rresp_err", md_err, 1);
    reset_n = 1'b0;
    #1;
    check("rresp_ready_low", md_ready, 0);
    check("rresp_err_low", md_err, 0);
    m_x = 0; m_b = 0; m_e = 0;
    check_counters("rresp");
    md_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("rresp_no_out", out_valid, 0);

    // Reset while in WAIT, then a normal transfer.
    run_xfer(32'hCAFEF00D, 0, 2, 0, 1'b0, 32'h0000F00D);
    md_data = 32'h11223344; md_offset = 2'd0; md_size = 3'd4; cfg_wait = 4'd5;
    md_valid = 1'b1;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    check("rwait_ready", md_ready, 0);
    m_x = 0; m_b = 0; m_e = 0;
    check_counters("rwait");
    md_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    run_xfer(32'h11223344, 0, 4, 2, 1'b0, 32'h11223344);

    // Randomized transfers against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] d = $urandom;
      int off = $urandom_range(0, 3);
      int sz  = $urandom_range(0, 7);
      int w   = $urandom_range(0, 3);
      bit lg  = ref_legal(off, sz);
      run_xfer(d, off, sz, w, !lg, lg ? ref_extract(d, off, sz) : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
